// File: rtl/data_pkg.sv
// Shared data-path types for the core memory path: address/data widths, byte
// enables, the RV32 load/store size encoding and the LSU state type.
package data;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NBYTE = XLEN / 8;

    typedef logic [XLEN-1:0]  addr_t;
    typedef logic [XLEN-1:0]  data_t;
    typedef logic [NBYTE-1:0] en_t;

    // RV32 funct3 encoding of access size and signedness
    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_t;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_RESP,
        LSU_HOLD
    } lsu_state_t;

    function automatic en_t op_mask(input mem_op_t op);
        en_t mask;
        case (op)
            MEM_B, MEM_BU: mask = 4'b0001;
            MEM_H, MEM_HU: mask = 4'b0011;
            MEM_W:         mask = 4'b1111;
            default:       mask = '0;
        endcase
        return mask;
    endfunction

    function automatic logic op_legal(input mem_op_t op, input logic store);
        logic ok;
        case (op)
            MEM_B, MEM_H, MEM_W: ok = 1'b1;
            MEM_BU, MEM_HU:      ok = !store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic op_misaligned(input mem_op_t op, input logic [1:0] lsb);
        logic mis;
        case (op)
            MEM_H, MEM_HU: mis = lsb[0];
            MEM_W:         mis = (lsb != 2'b00);
            default:       mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_format.sv
// Load data formatter: picks the low lanes of the RAM word and zero- or
// sign-extends them according to the access size.
module lsu_format
    import data::*;
(
    input  mem_op_t op,
    input  data_t   rdata,
    output data_t   data
);

    always_comb begin
        data = '0;
        case (op)
            MEM_B:   data = {{24{rdata[7]}}, rdata[7:0]};
            MEM_H:   data = {{16{rdata[15]}}, rdata[15:0]};
            MEM_W:   data = rdata;
            MEM_BU:  data = {24'd0, rdata[7:0]};
            MEM_HU:  data = {16'd0, rdata[15:0]};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit between execute and the byte-addressable synchronous RAM.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned H/HU/W into errors.
module lsu
    import data::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    req_valid,
    output logic    req_ready,
    input  logic    req_store,
    input  mem_op_t req_op,
    input  addr_t   req_addr,
    input  data_t   req_wdata,
    output logic    resp_valid,
    input  logic    resp_ready,
    output data_t   resp_rdata,
    output logic    resp_err,
    output en_t     ram_wen,
    output addr_t   ram_addr,
    output data_t   ram_wdata,
    input  data_t   ram_rdata
);

    lsu_state_t state_q, state_d;
    mem_op_t    op_q;
    logic       store_q;
    logic       err_q;
    data_t      hold_q;

    logic  ready_int;
    logic  take;
    logic  req_err;
    logic  hold_load;
    data_t fmt_data;
    data_t resp_live;

    always_comb begin
        req_err = !op_legal(req_op, req_store);
`ifdef LSU_MISALIGN_TRAP_EN
        if (op_misaligned(req_op, req_addr[1:0])) begin
            req_err = 1'b1;
        end
`endif
    end

    // Flop enables use the ungated ready; reset already holds every flop, so
    // only the externally visible handshake and write enable need resetn.
    always_comb begin
        ready_int = 1'b0;
        case (state_q)
            LSU_IDLE: ready_int = 1'b1;
            LSU_RESP: ready_int = resp_ready;
            default:  ready_int = 1'b0;
        endcase
    end

    assign take      = req_valid && ready_int;
    assign req_ready = ready_int && resetn;

    assign ram_addr  = req_addr;
    assign ram_wdata = req_wdata;
    assign ram_wen   = (take && resetn && req_store && !req_err) ? op_mask(req_op) : '0;

    lsu_format u_format (
        .op    (op_q),
        .rdata (ram_rdata),
        .data  (fmt_data)
    );

    assign resp_live = (store_q || err_q) ? '0 : fmt_data;

    always_comb begin
        state_d    = state_q;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        hold_load  = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                if (take) begin
                    state_d = LSU_RESP;
                end
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = resp_live;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_d = take ? LSU_RESP : LSU_IDLE;
                end else begin
                    // RAM read data is only valid for one cycle, so park it
                    hold_load = 1'b1;
                    state_d   = LSU_HOLD;
                end
            end
            LSU_HOLD: begin
                resp_valid = 1'b1;
                resp_rdata = hold_q;
                resp_err   = err_q;
                if (resp_ready) begin
                    state_d = LSU_IDLE;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= LSU_IDLE;
            op_q    <= MEM_B;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                op_q    <= req_op;
                store_q <= req_store;
                err_q   <= req_err;
            end
            if (hold_load) begin
                hold_q <= resp_live;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, backpressure and reset
// sequences, then randomized traffic against a byte-array reference model.
module tb_lsu;
    import data::*;

    logic    clk = 1'b0;
    logic    resetn;
    logic    req_valid;
    logic    req_ready;
    logic    req_store;
    mem_op_t req_op;
    addr_t   req_addr;
    data_t   req_wdata;
    logic    resp_valid;
    logic    resp_ready;
    data_t   resp_rdata;
    logic    resp_err;
    en_t     ram_wen;
    addr_t   ram_addr;
    data_t   ram_wdata;
    data_t   ram_rdata;

    int checks   = 0;
    int failures = 0;

    lsu dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous byte-lane RAM: lane i holds byte addr+i, one-cycle read.
    logic [7:0] mem [0:1023];
    initial for (int i = 0; i < 1024; i++) mem[i] = 8'h00;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_wen[i]) mem[10'(ram_addr + 32'(i))] <= ram_wdata[8*i +: 8];
        end
        ram_rdata <= {mem[10'(ram_addr + 32'd3)], mem[10'(ram_addr + 32'd2)],
                      mem[10'(ram_addr + 32'd1)], mem[10'(ram_addr)]};
    end

    // Reference model memory, updated only from the bench's own store rules
    logic [7:0] ref_mem [0:1023];
    initial for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic ref_err(input logic st, input logic [2:0] op, input logic [31:0] a);
        logic bad;
        bad = !((op <= 3'd2) || (!st && (op == 3'd4 || op == 3'd5)));
`ifdef LSU_MISALIGN_TRAP_EN
        if ((op[1:0] == 2'd1) && (a % 2 != 0)) bad = 1'b1;
        if ((op == 3'd2) && (a % 4 != 0)) bad = 1'b1;
`else
        if (a == 32'hFFFF_FFFF) bad = bad;
`endif
        return bad;
    endfunction

    function automatic int ref_size(input logic [2:0] op);
        return (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
        longint v = 0;
        int n = ref_size(op);
        for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(ref_mem[10'(a + 32'(i))]);
        if (op[2] == 1'b0 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    typedef struct {
        logic        st;
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wen;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic st, input logic [2:0] op, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wen,
                                input logic [31:0] rdata, input logic err);
        vec_t v;
        v.st = st; v.op = op; v.addr = addr; v.wdata = wdata;
        v.wen = wen; v.rdata = rdata; v.err = err;
        tbl.push_back(v);
    endfunction

    task automatic idle_inputs();
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_op     = MEM_W;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
    endtask

    // One request with immediate consumption; checks request and response cycles
    task automatic do_req(input vec_t v, input string name);
        @(posedge clk); #1;
        req_valid  = 1'b1;
        req_store  = v.st;
        req_op     = mem_op_t'(v.op);
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        resp_ready = 1'b1;
        @(negedge clk);
        chk({name, ".req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({name, ".ram_wen"}, {28'd0, ram_wen}, {28'd0, v.wen});
        chk({name, ".ram_addr"}, ram_addr, v.addr);
        chk({name, ".ram_wdata"}, ram_wdata, v.wdata);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk({name, ".resp_valid"}, {31'd0, resp_valid}, 32'd1);
        chk({name, ".resp_rdata"}, resp_rdata, v.rdata);
        chk({name, ".resp_err"}, {31'd0, resp_err}, {31'd0, v.err});
    endtask

    task automatic lw(input logic [31:0] a, input logic [31:0] exp, input string name);
        vec_t v;
        v.st = 1'b0; v.op = 3'd2; v.addr = a; v.wdata = 32'hFFFF_FFFF;
        v.wen = 4'd0; v.rdata = exp; v.err = 1'b0;
        do_req(v, name);
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d, input string name);
        vec_t v;
        v.st = 1'b1; v.op = 3'd2; v.addr = a; v.wdata = d;
        v.wen = 4'hF; v.rdata = 32'd0; v.err = 1'b0;
        do_req(v, name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with a store presented: nothing may leak out
        resetn     = 1'b0;
        req_valid  = 1'b1;
        req_store  = 1'b1;
        req_op     = MEM_W;
        req_addr   = 32'h0000_0040;
        req_wdata  = 32'hCAFE_F00D;
        resp_ready = 1'b1;
        #3;
        chk("rst.req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst.ram_wen", {28'd0, ram_wen}, 32'd0);
        chk("rst.ram_addr", ram_addr, 32'h0000_0040);
        chk("rst.ram_wdata", ram_wdata, 32'hCAFE_F00D);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        resetn = 1'b1;

        // Directed vector table
        add(1, 3'd2, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        add(1, 3'd0, 32'h11, 32'h00000055, 4'h1, 32'h0, 0);
        add(0, 3'd2, 32'h10, 32'hFFFFFFFF, 4'h0, 32'hDEAD55EF, 0);
        add(1, 3'd2, 32'h10, 32'h80000000, 4'hF, 32'h0, 0);
        add(0, 3'd0, 32'h13, 32'hFFFFFFFF, 4'h0, 32'hFFFFFF80, 0);
        add(0, 3'd4, 32'h13, 32'hFFFFFFFF, 4'h0, 32'h00000080, 0);
        add(0, 3'd1, 32'h12, 32'hFFFFFFFF, 4'h0, 32'hFFFF8000, 0);
        add(0, 3'd5, 32'h12, 32'hFFFFFFFF, 4'h0, 32'h00008000, 0);
        add(1, 3'd3, 32'h20, 32'h12345678, 4'h0, 32'h0, 1);
        add(0, 3'd6, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
        add(0, 3'd7, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
        add(1, 3'd4, 32'h10, 32'h000000FF, 4'h0, 32'h0, 1);
        add(0, 3'd2, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h80000000, 0);
        add(1, 3'd2, 32'h00, 32'h11223344, 4'hF, 32'h0, 0);
        add(1, 3'd2, 32'h04, 32'h55667788, 4'hF, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        add(0, 3'd2, 32'h02, 32'hFFFFFFFF, 4'h0, 32'h0, 1);
        add(1, 3'd1, 32'h01, 32'h0000ABCD, 4'h0, 32'h0, 1);
        add(0, 3'd2, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h11223344, 0);
`else
        add(0, 3'd2, 32'h02, 32'hFFFFFFFF, 4'h0, 32'h77881122, 0);
        add(1, 3'd1, 32'h01, 32'h0000ABCD, 4'h3, 32'h0, 0);
        add(0, 3'd2, 32'h00, 32'hFFFFFFFF, 4'h0, 32'h11ABCD44, 0);
`endif
        for (int i = 0; i < tbl.size(); i++) do_req(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: LW @0 held three cycles while LW @4 waits
        sw(32'h0, 32'hA5A50001, "bp.sw0");
        sw(32'h4, 32'h5A5A0002, "bp.sw4");
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_op = MEM_W; req_addr = 32'h0; resp_ready = 1'b0;
        @(negedge clk);
        chk("bp.accept0", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_addr = 32'h4;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("bp.held_valid%0d", c), {31'd0, resp_valid}, 32'd1);
            chk($sformatf("bp.held_data%0d", c), resp_rdata, 32'hA5A50001);
            chk($sformatf("bp.held_ready%0d", c), {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp.first_data", resp_rdata, 32'hA5A50001);
        chk("bp.hold_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.idle_valid", {31'd0, resp_valid}, 32'd0);
        chk("bp.accept4", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("bp.second_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp.second_data", resp_rdata, 32'h5A5A0002);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp.no_dup", {31'd0, resp_valid}, 32'd0);

        // Reset while in HOLD
        @(posedge clk); #1;
        req_valid = 1'b1; req_store = 1'b0; req_op = MEM_W; req_addr = 32'h4; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold.valid", {31'd0, resp_valid}, 32'd1);
        #2;
        req_valid = 1'b1; req_store = 1'b1; req_op = MEM_W; req_addr = 32'h8; req_wdata = 32'hBAD0BAD0;
        resetn = 1'b0;
        #1;
        chk("hrst.resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("hrst.req_ready", {31'd0, req_ready}, 32'd0);
        chk("hrst.resp_rdata", resp_rdata, 32'd0);
        chk("hrst.ram_wen", {28'd0, ram_wen}, 32'd0);
        @(negedge clk);
        idle_inputs();
        resetn = 1'b1;
        lw(32'h4, 32'h5A5A0002, "hrst.lw4");
        lw(32'h8, 32'h0, "hrst.lw8");

        // Randomized traffic in a region the directed tests never touched
        begin
            logic [31:0] exp_q[$];
            logic        err_q[$];
            logic        held = 1'b0;
            for (int n = 0; n < 600; n++) begin
                logic        exp_ready, acc, e;
                logic [2:0]  op;
                logic [31:0] a;
                logic [3:0]  exp_wen;
                @(posedge clk); #1;
                op         = 3'($urandom_range(0, 7));
                a          = 32'h100 + $urandom_range(0, 63);
                req_valid  = ($urandom_range(0, 3) != 0);
                req_store  = $urandom_range(0, 1) == 1;
                req_op     = mem_op_t'(op);
                req_addr   = a;
                req_wdata  = $urandom;
                resp_ready = ($urandom_range(0, 9) < 7);
                @(negedge clk);
                exp_ready = (exp_q.size() == 0) ? 1'b1 : (held ? 1'b0 : resp_ready);
                chk("rnd.req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
                chk("rnd.resp_valid", {31'd0, resp_valid}, {31'd0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    chk("rnd.resp_rdata", resp_rdata, exp_q[0]);
                    chk("rnd.resp_err", {31'd0, resp_err}, {31'd0, err_q[0]});
                end
                acc = req_valid && exp_ready;
                e   = ref_err(req_store, op, a);
                exp_wen = (acc && req_store && !e) ? 4'((1 << ref_size(op)) - 1) : 4'd0;
                chk("rnd.ram_wen", {28'd0, ram_wen}, {28'd0, exp_wen});
                if (exp_q.size() != 0) begin
                    if (resp_ready) begin
                        void'(exp_q.pop_front());
                        void'(err_q.pop_front());
                        held = 1'b0;
                    end else begin
                        held = 1'b1;
                    end
                end
                if (acc) begin
                    exp_q.push_back((req_store || e) ? 32'd0 : ref_load(op, a));
                    err_q.push_back(e);
                    if (req_store && !e) begin
                        for (int i = 0; i < ref_size(op); i++)
                            ref_mem[10'(a + 32'(i))] = req_wdata[8*i +: 8];
                    end
                end
            end
        end

        idle_inputs();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the byte-addressable synchronous data RAM (`ram`). Accepts one memory request per cycle over a valid/ready handshake and drives the RAM port (`wen`, `addr`, `wdata`) directly. Captures the one-cycle-latency read data, then zero- or sign-extends it. Returns exactly one response per request to writeback, with backpressure buffering.

## Interface
- No parameters; widths come from package `data` (`addr_t`, `data_t`, `en_t`, `mem_op_t`).
- `clk`  in  1  clock; everything sampled on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_store`  in  1  1 = store, 0 = load.
- `req_op`  in  `mem_op_t` (3)  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `req_addr`  in  `addr_t`  byte address.
- `req_wdata`  in  `data_t`  store data, least-significant bytes used.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  response consumed when `resp_valid && resp_ready`.
- `resp_rdata`  out  `data_t`  extended load data; 0 for stores and errors.
- `resp_err`  out  1  illegal op, or misaligned access when the trap feature is compiled in.
- `ram_wen`  out  `en_t` (4)  per-byte write enable to RAM.
- `ram_addr`  out  `addr_t`  RAM address.
- `ram_wdata`  out  `data_t`  RAM write data.
- `ram_rdata`  in  `data_t`  RAM read data, valid one cycle after the address is sampled.

## Operation
- Lane mapping: RAM lane i holds byte `addr+i`, so the LSU never shifts data.
  - Byte: `wen=0001`. Half: `wen=0011`. Word: `wen=1111`.
  - `ram_wdata = req_wdata` unmodified.
- `ram_addr`, `ram_wdata` and `ram_wen` are combinational from the request.
  - `ram_wen` is nonzero only on an accepted, legal store.
  - `ram_addr = req_addr` in every cycle.
- Load formatting from lane 0 up:
  - B sign-extends `[7:0]`; H sign-extends `[15:0]`; W passes through.
  - BU/HU zero-extend.
- Illegal ops: 011, 110, 111, and stores with op 100/101.
  - No write is performed.
  - Response carries `resp_err=1` and `resp_rdata=0`.
- Address wrap at the top of memory follows RAM `addr+i` modulo 2^`$bits(addr_t)`. The LSU does not check for it.
- State machine, with the response-side info (kind/op/err) held in registers:
  - **IDLE**: `resp_valid=0`, `req_ready=1`. Accept → RESP.
  - **RESP**: `resp_valid=1`; data is formatted from live `ram_rdata`; `req_ready=resp_ready`.
    - Consumed and new request accepted → RESP.
    - Consumed, no request → IDLE.
    - Not consumed → capture formatted data into `hold_q` → HOLD.
  - **HOLD**: `resp_valid=1`; data comes from `hold_q`; `req_ready=0`. Consumed → IDLE.
- Reset (any time, including mid-response):
  - Asynchronous to IDLE.
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`, `hold_q=0`, `req_ready=0`, `ram_wen=0` while `resetn` is low.
  - Any in-flight response is dropped.

## Timing
- Request accepted in cycle T; RAM samples `ram_addr` and `ram_wen` at the end of T.
- Response valid in T+1 for both loads and stores, so load-to-use latency is 1.
- Throughput is one request per cycle while `resp_ready=1`.
- `resp_ready` low in T+1 gives HOLD from T+2. `resp_*` stays stable until consumed.
- A store in T is visible to a load accepted in T+1.
- Outputs at reset: `req_ready=0`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`, `ram_wen=0`, `ram_wdata=req_wdata`, `ram_addr=req_addr`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses are trapped: H/HU with `addr[0]=1`, W with `addr[1:0]≠0`.
  - The trapped access gets `ram_wen=0`, and its response has `resp_err=1` and `resp_rdata=0`, still in T+1.
- Not defined: misaligned accesses proceed normally, since the RAM is byte-addressable.

## Structure
- Package `data` gains:
  - `en_t`, moved out of the RAM file.
  - `mem_op_t` enum: `MEM_B`, `MEM_H`, `MEM_W`, `MEM_BU`, `MEM_HU`.
- Sub-module `lsu_format`: combinational extraction and extension of (`op`, `rdata`) to `data_t`. It is used by the RESP-path mux.

## Test plan
1. **Stores:** SW 0xDEADBEEF @0x10, then SB 0x55 @0x11 → `ram_wen` 1111 then 0001; LW @0x10 → 0xDEAD55EF in T+1.
2. **Sign vs zero extension:** LB @0x13 after storing word 0x80000000 @0x10 → 0xFFFFFF80; LBU → 0x00000080; LH @0x12 → 0xFFFF8000.
3. **Backpressure:**
   - Back-to-back LW @0x0, 0x4 with `resp_ready` low for 3 cycles at the first response → first data held stable, `req_ready=0`.
   - Both responses delivered in order with no duplication.
4. **Misalignment:** LW @0x2. With `LSU_MISALIGN_TRAP_EN` → `resp_err=1`, `resp_rdata=0`. Without it → bytes 2..5 returned. SH @0x1 writes nothing with the macro defined.
5. **Illegal op:** op 011 store → `ram_wen=0`, `resp_err=1`, in both builds.
6. **Reset:** reset asserted in HOLD → `resp_valid` drops immediately; after release the next LW returns fresh data in T+1.
